// File: rtl/rr_arbiter_param_if.sv
// Request/grant bundle between N masters and the round-robin arbiter.
// master: requester side; slave: arbiter side.
interface rr_arbiter_param_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;

  modport master (
    output req,
    input  grant,
    input  grant_idx,
    input  grant_valid
  );

  modport slave (
    input  req,
    output grant,
    output grant_idx,
    output grant_valid
  );
endinterface

// File: rtl/rr_arbiter_param.sv
// N-way round-robin arbiter with registered one-hot grant, held while the owner requests.
// Define RR_ARB_TIMEOUT_EN to force rotation after MAX_HOLD cycles when others are waiting.
module rr_arbiter_param #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 16
) (
  input logic               clk,
  input logic               rst,
  rr_arbiter_param_if.slave bus
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || MAX_HOLD < 2) begin : g_param_check
    $error("rr_arbiter_param: N and MAX_HOLD must both be >= 2");
  end

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [N-1:0]     others;
  logic [IDX_W-1:0] pick_idle, pick_next;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD);
  logic [HOLD_W-1:0] hold_q, hold_d;
`endif

  // First set bit of r scanning from+1, from+2, ... wrapping; from itself is lowest priority.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0] r,
                                               input logic [IDX_W-1:0] from);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    pick = from;
    for (int unsigned k = N; k >= 1; k--) begin
      cand = IDX_W'((32'(from) + k) % N);
      if (r[cand]) pick = cand;
    end
    return pick;
  endfunction

  function automatic logic [N-1:0] to_onehot(input logic [IDX_W-1:0] i);
    logic [N-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    return oh;
  endfunction

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    last_d    = last_q;
`ifdef RR_ARB_TIMEOUT_EN
    hold_d    = hold_q;
`endif
    others    = bus.req & ~grant_q;
    pick_idle = rr_pick(bus.req, last_q);
    pick_next = rr_pick(others, idx_q);

    case (state_q)
      StIdle: begin
        if (|bus.req) begin
          state_d = StBusy;
          grant_d = to_onehot(pick_idle);
          idx_d   = pick_idle;
`ifdef RR_ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      StBusy: begin
        if (!bus.req[idx_q]) begin
          last_d = idx_q;
          if (|others) begin
            // Hand over directly, no idle bubble.
            grant_d = to_onehot(pick_next);
            idx_d   = pick_next;
`ifdef RR_ARB_TIMEOUT_EN
            hold_d  = '0;
`endif
          end else begin
            state_d = StIdle;
            grant_d = '0;
            idx_d   = '0;
          end
        end
`ifdef RR_ARB_TIMEOUT_EN
        else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
          // Expiry: rotate only if someone else is waiting, else restart the count.
          hold_d = '0;
          if (|others) begin
            last_d  = idx_q;
            grant_d = to_onehot(pick_next);
            idx_d   = pick_next;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
`endif
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      idx_q   <= '0;
      last_q  <= IDX_W'(N - 1);
`ifdef RR_ARB_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
`ifdef RR_ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = |grant_q;

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Self-checking bench for rr_arbiter_param (N=4, MAX_HOLD=4): directed scenarios plus
// randomized requests against a behavioural round-robin model.
module tb_rr_arbiter_param;

  localparam int unsigned N        = 4;
  localparam int unsigned MAX_HOLD = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  rr_arbiter_param_if #(.N(N)) bus ();

  rr_arbiter_param #(
    .N       (N),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  // Reference model: who owns the resource, who was served last, cycles held so far.
  bit m_busy;
  int m_owner;
  int m_last;
  int m_held;

  function automatic int first_after(input logic [N-1:0] r, input int from);
    for (int k = 1; k <= int'(N); k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return from;
  endfunction

  function automatic void model_step(input logic r_rst, input logic [N-1:0] r);
    logic [N-1:0] waiting;
    if (r_rst) begin
      m_busy = 0; m_owner = 0; m_last = N - 1; m_held = 0;
    end else if (!m_busy) begin
      if (r != '0) begin
        m_busy = 1; m_owner = first_after(r, m_last); m_held = 0;
      end
    end else begin
      waiting = r;
      waiting[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        m_last = m_owner;
        if (waiting != '0) begin
          m_owner = first_after(waiting, m_owner); m_held = 0;
        end else begin
          m_busy = 0;
        end
      end else if (TimeoutEn) begin
        m_held = m_held + 1;
        if (m_held == int'(MAX_HOLD)) begin
          m_held = 0;
          if (waiting != '0) begin
            m_last = m_owner; m_owner = first_after(waiting, m_owner);
          end
        end
      end
    end
  endfunction

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_busy) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(rst, bus.req);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 4'b1011;
    tick();
    tick();
    n_checks++;
    if (bus.grant !== 4'b0000) begin
      n_errors++; $display("FAIL reset_grant: got %b expected 0000", bus.grant);
    end
    n_checks++;
    if (bus.grant_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_valid: got %b expected 0", bus.grant_valid);
    end
    n_checks++;
    if (bus.grant_idx !== 2'd0) begin
      n_errors++; $display("FAIL reset_idx: got %0d expected 0", bus.grant_idx);
    end
    rst = 1'b0;
    bus.req = '0;
  endtask

  task automatic test_rotation();
    logic [N-1:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b1; bus.req = '0; tick(); rst = 1'b0;
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (bus.grant !== seq[i] || bus.grant_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL rotation[%0d]: got %b/%b expected %b/1", i, bus.grant, bus.grant_valid,
                 seq[i]);
      end
      bus.req = 4'b1111 & ~seq[i];
    end
    bus.req = '0;
    tick();
    n_checks++;
    if (bus.grant !== 4'b0000) begin
      n_errors++; $display("FAIL rotation_idle: got %b expected 0000", bus.grant);
    end
  endtask

  task automatic test_single_pulse();
    bus.req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.grant !== 4'b0100 || bus.grant_idx !== 2'd2 || bus.grant_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL single[%0d]: got %b idx %0d expected 0100 idx 2", i, bus.grant,
                 bus.grant_idx);
      end
    end
    bus.req = '0;
    tick();
    n_checks++;
    if (bus.grant !== 4'b0000 || bus.grant_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL single_release: got %b/%b expected 0000/0", bus.grant, bus.grant_valid);
    end
  endtask

  task automatic test_wrap();
    bus.req = 4'b1000;
    tick();
    n_checks++;
    if (bus.grant !== 4'b1000 || bus.grant_idx !== 2'd3) begin
      n_errors++; $display("FAIL wrap_owner3: got %b expected 1000", bus.grant);
    end
    bus.req = 4'b0011;
    tick();
    n_checks++;
    if (bus.grant !== 4'b0001 || bus.grant_idx !== 2'd0) begin
      n_errors++; $display("FAIL wrap_next: got %b expected 0001", bus.grant);
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_timeout();
    logic [N-1:0] exp_g;
    rst = 1'b1; tick(); rst = 1'b0;
    bus.req = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_g = (TimeoutEn && ((i / MAX_HOLD) % 2 == 1)) ? 4'b0010 : 4'b0001;
      n_checks++;
      if (bus.grant !== exp_g) begin
        n_errors++; $display("FAIL timeout[%0d]: got %b expected %b", i, bus.grant, exp_g);
      end
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_single_hold();
    int bad;
    bad = 0;
    bus.req = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.grant !== 4'b0100) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++; $display("FAIL single_hold: %0d cycles lost grant, expected 0", bad);
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_reset_midgrant();
    rst = 1'b1; tick(); rst = 1'b0;
    bus.req = 4'b0010;
    tick();
    n_checks++;
    if (bus.grant !== 4'b0010) begin
      n_errors++; $display("FAIL midrst_pre: got %b expected 0010", bus.grant);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus.grant !== 4'b0000 || bus.grant_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_drop: got %b/%b expected 0000/0", bus.grant, bus.grant_valid);
    end
    rst = 1'b0;
    bus.req = 4'b1010;
    tick();
    n_checks++;
    if (bus.grant !== 4'b0010) begin
      n_errors++; $display("FAIL midrst_after: got %b expected 0010", bus.grant);
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_random();
    int           wait_cnt [N];
    int           worst;
    logic [N-1:0] prev_g;
    logic [N-1:0] req_edge;
    logic [N-1:0] nr;
    rst = 1'b1; bus.req = '0; tick(); rst = 1'b0;
    for (int i = 0; i < int'(N); i++) wait_cnt[i] = 0;
    prev_g = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      nr = bus.req;
      for (int b = 0; b < int'(N); b++) begin
        if ($urandom_range(0, 5) == 0) nr[b] = ~nr[b];
      end
      bus.req  = nr;
      req_edge = nr;
      tick();
      n_checks++;
      if (bus.grant !== model_grant() || bus.grant_valid !== m_busy ||
          bus.grant_idx !== (m_busy ? 2'(m_owner) : 2'd0)) begin
        n_errors++;
        $display("FAIL random_model[%0d]: got %b idx %0d v %b expected %b idx %0d v %b", cyc,
                 bus.grant, bus.grant_idx, bus.grant_valid, model_grant(),
                 m_busy ? m_owner : 0, m_busy);
      end
      n_checks++;
      if (!$onehot0(bus.grant) ||
          (bus.grant_valid && bus.grant[bus.grant_idx] !== 1'b1)) begin
        n_errors++;
        $display("FAIL random_onehot[%0d]: got grant %b idx %0d", cyc, bus.grant,
                 bus.grant_idx);
      end
      worst = 0;
      for (int r = 0; r < int'(N); r++) begin
        if (!req_edge[r] || bus.grant[r]) wait_cnt[r] = 0;
        else if (bus.grant != prev_g && bus.grant != '0) wait_cnt[r]++;
        if (wait_cnt[r] > worst) worst = wait_cnt[r];
      end
      n_checks++;
      if (worst > int'(N)) begin
        n_errors++;
        $display("FAIL random_starve[%0d]: waited %0d grants, limit %0d", cyc, worst, N);
      end
      prev_g = bus.grant;
    end
    bus.req = '0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    bus.req  = '0;
    m_busy   = 0; m_owner = 0; m_last = N - 1; m_held = 0;
    test_reset();
    test_rotation();
    test_single_pulse();
    test_wrap();
    test_timeout();
    test_single_hold();
    test_reset_midgrant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
